// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a run of words out of a 256x32 block RAM.
// On a start it issues sequential reads from a base address, absorbs the
// one-cycle RAM read latency and delivers the words through a 2-entry FIFO
// as a valid/ready stream with a last-word marker.
// o_re is derived from registered state and this cycle's pop, so the credit
// check sees the slot being freed now; that keeps a 2-deep FIFO at one
// word per cycle without overflow.
module ram_stream_reader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_re,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_tvalid,
    input  logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic       head_valid;
    logic       head_last;
    logic       pop;
    logic       push;
    logic       accept_start;
    logic [2:0] occ_sum;
    logic       credit_ok;
    logic       issue;
    logic       issue_last;

    assign head_valid   = (count_q != 2'd0);
    assign head_last    = fifo_last_q[rd_ptr_q];
    assign pop          = head_valid && i_tready;
    assign push         = inflight_q;
    assign accept_start = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign occ_sum      = {1'b0, count_q} + {2'b00, inflight_q};
    assign credit_ok    = pop ? (occ_sum < 3'd3) : (occ_sum < 3'd2);
    assign issue        = (state_q == S_RUN) && credit_ok;
    assign issue_last   = issue && (issue_cnt_q == (len_q - (ADDR_W+1)'(1)));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_start) state_d = (i_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issue_last) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_d = S_DONE;
            S_DONE:  begin
                if (accept_start) state_d = (i_len == '0) ? S_DONE : S_RUN;
                else              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
        o_done   = (state_q == S_DONE);
        o_re     = issue;
        o_raddr  = raddr_q;
        o_tvalid = head_valid;
        o_tdata  = fifo_data_q[rd_ptr_q];
        o_tlast  = head_valid && head_last;
    end

    // Transfer counters, in-flight tracking and FIFO next values
    always_comb begin
        raddr_d         = raddr_q;
        len_d           = len_q;
        issue_cnt_d     = issue_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue_last;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;

        if (accept_start) begin
            raddr_d     = i_base;
            len_d       = i_len;
            issue_cnt_d = '0;
        end else if (issue) begin
            raddr_d     = raddr_q + ADDR_W'(1);
            issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = i_rdata;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raddr_q         <= '0;
            len_q           <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            raddr_q         <= raddr_d;
            len_q           <= len_d;
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // A returning word must always find a free FIFO slot
    fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural RAM, an address
// queue and a word scoreboard filled when each transfer is started.
module tb_ram_stream_reader;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [AW-1:0] i_base;
    logic [AW:0]   i_len;
    logic          o_busy, o_done, o_re;
    logic [AW-1:0] o_raddr;
    logic [DW-1:0] i_rdata = '0;
    logic          o_tvalid;
    logic          i_tready;
    logic [DW-1:0] o_tdata;
    logic          o_tlast;

    always #5 i_clk = ~i_clk;

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base(i_base),
        .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_re(o_re),
        .o_raddr(o_raddr), .i_rdata(i_rdata), .o_tvalid(o_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast)
    );

    logic [31:0] mem [256];
    always @(posedge i_clk) if (o_re) i_rdata <= mem[o_raddr];

    typedef struct packed { logic [31:0] d; logic l; } word_t;
    word_t      sq [$];
    logic [7:0] aq [$];

    int errors = 0, checks = 0;
    int occ = 0, words = 0, tlasts = 0, dones = 0;
    logic re_prev = 1'b0, hold_v = 1'b0, hold_l = 1'b0;
    logic [31:0] hold_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle observation: scoreboard, address order, occupancy, stall hold
    task automatic sample();
        logic pop;
        word_t e;
        @(negedge i_clk);
        pop = o_tvalid & i_tready;
        chk("occ_le2", 32'(occ <= 2), 32'd1);
        chk("tvalid_vs_model", 32'(o_tvalid), 32'(occ != 0));
        if (hold_v) begin
            chk("stall_valid", 32'(o_tvalid), 32'd1);
            chk("stall_data", o_tdata, hold_d);
            chk("stall_last", 32'(o_tlast), 32'(hold_l));
        end
        if (o_re) begin
            if (aq.size() == 0) chk("read_unexpected", 32'(aq.size()), 32'd1);
            else                chk("raddr", 32'(o_raddr), 32'(aq.pop_front()));
        end
        if (pop) begin
            if (sq.size() == 0) chk("word_unexpected", 32'(sq.size()), 32'd1);
            else begin
                e = sq.pop_front();
                chk("tdata", o_tdata, e.d);
                chk("tlast", 32'(o_tlast), 32'(e.l));
            end
            words++;
            if (o_tlast) tlasts++;
        end
        if (o_done) dones++;
        occ     = occ + int'(re_prev) - int'(pop);
        re_prev = o_re;
        hold_v  = o_tvalid & ~i_tready;
        hold_d  = o_tdata;
        hold_l  = o_tlast;
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic [8:0] n);
        word_t w;
        logic [7:0] a;
        for (int k = 0; k < int'(n); k++) begin
            a = b + 8'(k);
            aq.push_back(a);
            w.d = mem[a];
            w.l = (k == int'(n) - 1);
            sq.push_back(w);
        end
    endtask

    // Called at one cycle's drive point; returns in cycle 1 of the transfer
    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        i_start = 1'b1; i_base = b; i_len = n;
        push_exp(b, n);
        sample();
        adv();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        logic f;
        f = 1'b0; n = 0;
        while (!f && n < budget) begin
            adv(); sample(); n++;
            if (o_done) f = 1'b1;
        end
        chk("done_seen", 32'(f), 32'd1);
    endtask

    task automatic check_zero();
        chk("z_busy", 32'(o_busy), 32'd0);
        chk("z_done", 32'(o_done), 32'd0);
        chk("z_re", 32'(o_re), 32'd0);
        chk("z_raddr", 32'(o_raddr), 32'd0);
        chk("z_tvalid", 32'(o_tvalid), 32'd0);
        chk("z_tdata", o_tdata, 32'd0);
        chk("z_tlast", 32'(o_tlast), 32'd0);
    endtask

    initial begin
        int n, w0, t0, d0;
        for (int k = 0; k < 256; k++) mem[k] = 32'hA500_0000 + 32'(k);
        i_rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_len = '0; i_tready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 check_zero();
        adv();
        i_rst_n = 1'b1;

        // Basic 8-word transfer, consumer always ready
        start_xfer(8'h10, 9'd8);
        sample();
        chk("t1_c1_busy", 32'(o_busy), 32'd1);
        chk("t1_c1_re", 32'(o_re), 32'd1);
        adv(); sample();
        chk("t1_c2_tvalid", 32'(o_tvalid), 32'd0);
        adv(); sample();
        chk("t1_c3_tvalid", 32'(o_tvalid), 32'd1);
        chk("t1_c3_tdata", o_tdata, 32'hA500_0010);
        wait_done(40, n);
        chk("t1_done_cycle", 32'(n), 32'd8);
        chk("t1_busy_at_done", 32'(o_busy), 32'd0);
        adv(); sample();
        chk("t1_done_width", 32'(o_done), 32'd0);
        chk("t1_sb_empty", 32'(sq.size() + aq.size()), 32'd0);

        // Address wrap at the top of the buffer
        adv();
        start_xfer(8'hFE, 9'd4);
        sample();
        wait_done(40, n);
        chk("t2_done_cycle", 32'(n), 32'd6);
        chk("t2_sb_empty", 32'(sq.size() + aq.size()), 32'd0);

        // Full 256-word transfer with random backpressure
        adv();
        w0 = words; t0 = tlasts;
        i_tready = 1'($urandom_range(0, 1));
        start_xfer(8'h80, 9'd256);
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            i_tready = 1'($urandom_range(0, 1));
            sample();
            if (o_done) begin n = 1; break; end
            adv();
        end
        chk("t3_done_seen", 32'(n), 32'd1);
        chk("t3_words", 32'(words - w0), 32'd256);
        chk("t3_tlasts", 32'(tlasts - t0), 32'd1);
        chk("t3_sb_empty", 32'(sq.size() + aq.size()), 32'd0);
        adv();
        i_tready = 1'b1;

        // Zero-length transfer, then a 1-word start in its DONE cycle
        w0 = words; t0 = tlasts;
        start_xfer(8'h20, 9'd0);
        sample();
        chk("t4_done", 32'(o_done), 32'd1);
        chk("t4_busy", 32'(o_busy), 32'd0);
        chk("t4_re", 32'(o_re), 32'd0);
        i_start = 1'b1; i_base = 8'h33; i_len = 9'd1;
        push_exp(8'h33, 9'd1);
        adv();
        i_start = 1'b0;
        sample();
        chk("t4b_busy", 32'(o_busy), 32'd1);
        chk("t4b_re", 32'(o_re), 32'd1);
        wait_done(40, n);
        chk("t4b_done_cycle", 32'(n), 32'd3);
        chk("t4b_words", 32'(words - w0), 32'd1);
        chk("t4b_tlasts", 32'(tlasts - t0), 32'd1);

        // Start pulse while busy must be ignored
        adv();
        d0 = dones; w0 = words;
        start_xfer(8'h40, 9'd8);
        sample();
        i_start = 1'b1; i_base = 8'h90; i_len = 9'd3;
        adv();
        i_start = 1'b0;
        sample();
        wait_done(40, n);
        chk("t5_done_cycle", 32'(n), 32'd9);
        repeat (4) begin adv(); sample(); end
        chk("t5_done_count", 32'(dones - d0), 32'd1);
        chk("t5_words", 32'(words - w0), 32'd8);
        chk("t5_sb_empty", 32'(sq.size() + aq.size()), 32'd0);

        // Reset after three of eight words
        adv();
        w0 = words;
        start_xfer(8'h00, 9'd8);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (words - w0 == 3) begin n = 1; break; end
            adv();
        end
        chk("t6_three_words", 32'(n), 32'd1);
        d0 = dones;
        #1 i_rst_n = 1'b0;
        #1 check_zero();
        sq.delete(); aq.delete();
        occ = 0; re_prev = 1'b0; hold_v = 1'b0;
        adv();
        i_rst_n = 1'b1;
        repeat (3) begin sample(); adv(); end
        chk("t6_no_done", 32'(dones - d0), 32'd0);
        start_xfer(8'h05, 9'd3);
        sample();
        wait_done(40, n);
        chk("t6_restart_done_cycle", 32'(n), 32'd5);
        chk("t6_sb_empty", 32'(sq.size() + aq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
